// File: rtl/sparc_exu_ccr_pipe_pkg.sv
// Shared constants and pipe-stage payload for the EXU condition-code pipeline.
package sparc_exu_ccr_pipe_pkg;

    localparam int unsigned NTHREADS = 4;
    localparam int unsigned TID_W    = $clog2(NTHREADS);
    localparam int unsigned CCR_W    = 8;

    // CCR bit positions: xcc in the upper nibble, icc in the lower nibble
    localparam int unsigned XCC_N = 7;
    localparam int unsigned XCC_Z = 6;
    localparam int unsigned XCC_V = 5;
    localparam int unsigned XCC_C = 4;
    localparam int unsigned ICC_N = 3;
    localparam int unsigned ICC_Z = 2;
    localparam int unsigned ICC_V = 1;
    localparam int unsigned ICC_C = 0;

    typedef struct packed {
        logic             valid;
        logic [TID_W-1:0] tid;
        logic [CCR_W-1:0] ccr;
    } ccr_stage_t;

endpackage

// File: rtl/sparc_exu_ccr_flaggen.sv
// E-stage condition-code generator: builds icc/xcc from ALU adder or logic flags.
module sparc_exu_ccr_flaggen
    import sparc_exu_ccr_pipe_pkg::*;
(
    input  logic             is_logic,
    input  logic             is_sub,
    input  logic             rs1_63,
    input  logic             rs1_31,
    input  logic             in2_63,
    input  logic             in2_31,
    input  logic             add_n64,
    input  logic             add_n32,
    input  logic             log_n64,
    input  logic             log_n32,
    input  logic             zhigh,
    input  logic             zlow,
    input  logic             cout64_l,
    input  logic             cout32,
    output logic [CCR_W-1:0] flags_c
);

    always_comb begin
        flags_c        = '0;
        flags_c[XCC_Z] = zlow & zhigh;
        flags_c[ICC_Z] = zlow;
        if (is_logic) begin
            flags_c[XCC_N] = log_n64;
            flags_c[ICC_N] = log_n32;
        end else begin
            flags_c[XCC_N] = add_n64;
            flags_c[ICC_N] = add_n32;
            // overflow: operands share a sign and the sum's sign differs
            flags_c[XCC_V] = (rs1_63 == in2_63) & (add_n64 != rs1_63);
            flags_c[ICC_V] = (rs1_31 == in2_31) & (add_n32 != rs1_31);
            // subtract reports borrow, i.e. the inverted carry-out
            flags_c[XCC_C] = ~cout64_l ^ is_sub;
            flags_c[ICC_C] = cout32 ^ is_sub;
        end
    end

endmodule

// File: rtl/sparc_exu_ccr_pipe.sv
// Per-thread CCR pipeline: flags from E carried through M and W, committed at W,
// with youngest-first forwarding back to the thread in E.
module sparc_exu_ccr_pipe
    import sparc_exu_ccr_pipe_pkg::*;
(
    input  logic             rclk,
    input  logic             arst_l,
    input  logic             se,
    input  logic             si,
    output logic             so,
    input  logic             valid_e,
    input  logic [TID_W-1:0] tid_e,
    input  logic             setcc_e,
    input  logic             is_logic_e,
    input  logic             is_sub_e,
    input  logic             wrccr_e,
    input  logic [CCR_W-1:0] wrccr_data_e,
    input  logic             rs1_63_e,
    input  logic             rs1_31_e,
    input  logic             alu_ecl_adderin2_63_e,
    input  logic             alu_ecl_adderin2_31_e,
    input  logic             alu_ecl_add_n64_e,
    input  logic             alu_ecl_add_n32_e,
    input  logic             alu_ecl_log_n64_e,
    input  logic             alu_ecl_log_n32_e,
    input  logic             alu_ecl_zhigh_e,
    input  logic             alu_ecl_zlow_e,
    input  logic             alu_ecl_cout64_e_l,
    input  logic             alu_ecl_cout32_e,
    input  logic             flush_m,
    input  logic             flush_w,
    input  logic [TID_W-1:0] rd_tid,
    output logic [CCR_W-1:0] ccr_rd_data,
    output logic [CCR_W-1:0] ccr_cur_e,
    output logic             ecl_alu_cin_e
);

    logic [CCR_W-1:0] flags_e;
    logic [CCR_W-1:0] ccr_arr [NTHREADS];
    logic [CCR_W-1:0] arch_e;
    ccr_stage_t       stage_e;
    ccr_stage_t       stage_m;
    ccr_stage_t       stage_w;
    logic             live_m;
    logic             commit_w;
    logic             unused_scan;

    // scan chain is not modelled functionally
    assign so          = 1'b0;
    assign unused_scan = se ^ si;

    sparc_exu_ccr_flaggen u_flaggen (
        .is_logic (is_logic_e),
        .is_sub   (is_sub_e),
        .rs1_63   (rs1_63_e),
        .rs1_31   (rs1_31_e),
        .in2_63   (alu_ecl_adderin2_63_e),
        .in2_31   (alu_ecl_adderin2_31_e),
        .add_n64  (alu_ecl_add_n64_e),
        .add_n32  (alu_ecl_add_n32_e),
        .log_n64  (alu_ecl_log_n64_e),
        .log_n32  (alu_ecl_log_n32_e),
        .zhigh    (alu_ecl_zhigh_e),
        .zlow     (alu_ecl_zlow_e),
        .cout64_l (alu_ecl_cout64_e_l),
        .cout32   (alu_ecl_cout32_e),
        .flags_c  (flags_e)
    );

    // WRCCR data takes priority over ALU flags
    always_comb begin
        stage_e.valid = valid_e & (setcc_e | wrccr_e);
        stage_e.tid   = tid_e;
        stage_e.ccr   = wrccr_e ? wrccr_data_e : flags_e;
    end

    assign live_m   = stage_m.valid & ~flush_m;
    assign commit_w = stage_w.valid & ~flush_w;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            stage_m <= '0;
            stage_w <= '0;
        end else begin
            stage_m <= stage_e;
            stage_w <= '{valid: live_m, tid: stage_m.tid, ccr: stage_m.ccr};
        end
    end

    // tid values without a matching entry never commit
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int t = 0; t < int'(NTHREADS); t++) begin
                ccr_arr[t] <= '0;
            end
        end else begin
            for (int t = 0; t < int'(NTHREADS); t++) begin
                if (commit_w && (stage_w.tid == TID_W'(t))) begin
                    ccr_arr[t] <= stage_w.ccr;
                end
            end
        end
    end

    always_comb begin
        ccr_rd_data = '0;
        arch_e      = '0;
        for (int t = 0; t < int'(NTHREADS); t++) begin
            if (rd_tid == TID_W'(t)) ccr_rd_data = ccr_arr[t];
            if (tid_e == TID_W'(t))  arch_e      = ccr_arr[t];
        end
    end

    // youngest live same-thread entry wins
    always_comb begin
        ccr_cur_e = arch_e;
        if (live_m && (stage_m.tid == tid_e)) begin
            ccr_cur_e = stage_m.ccr;
        end else if (commit_w && (stage_w.tid == tid_e)) begin
            ccr_cur_e = stage_w.ccr;
        end
    end

    assign ecl_alu_cin_e = ccr_cur_e[ICC_C];

endmodule

// File: tb/tb_sparc_exu_ccr_pipe.sv
// Directed bench for the CCR pipeline: flag generation, latency, forwarding, flushes, reset.
module tb_sparc_exu_ccr_pipe;

    logic       rclk;
    logic       arst_l;
    logic       se;
    logic       si;
    logic       so;
    logic       valid_e;
    logic [1:0] tid_e;
    logic       setcc_e;
    logic       is_logic_e;
    logic       is_sub_e;
    logic       wrccr_e;
    logic [7:0] wrccr_data_e;
    logic       rs1_63_e;
    logic       rs1_31_e;
    logic       in2_63;
    logic       in2_31;
    logic       add_n64;
    logic       add_n32;
    logic       log_n64;
    logic       log_n32;
    logic       zhigh;
    logic       zlow;
    logic       cout64_l;
    logic       cout32;
    logic       flush_m;
    logic       flush_w;
    logic [1:0] rd_tid;
    logic [7:0] ccr_rd_data;
    logic [7:0] ccr_cur_e;
    logic       ecl_alu_cin_e;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    sparc_exu_ccr_pipe dut (
        .rclk                  (rclk),
        .arst_l                (arst_l),
        .se                    (se),
        .si                    (si),
        .so                    (so),
        .valid_e               (valid_e),
        .tid_e                 (tid_e),
        .setcc_e               (setcc_e),
        .is_logic_e            (is_logic_e),
        .is_sub_e              (is_sub_e),
        .wrccr_e               (wrccr_e),
        .wrccr_data_e          (wrccr_data_e),
        .rs1_63_e              (rs1_63_e),
        .rs1_31_e              (rs1_31_e),
        .alu_ecl_adderin2_63_e (in2_63),
        .alu_ecl_adderin2_31_e (in2_31),
        .alu_ecl_add_n64_e     (add_n64),
        .alu_ecl_add_n32_e     (add_n32),
        .alu_ecl_log_n64_e     (log_n64),
        .alu_ecl_log_n32_e     (log_n32),
        .alu_ecl_zhigh_e       (zhigh),
        .alu_ecl_zlow_e        (zlow),
        .alu_ecl_cout64_e_l    (cout64_l),
        .alu_ecl_cout32_e      (cout32),
        .flush_m               (flush_m),
        .flush_w               (flush_w),
        .rd_tid                (rd_tid),
        .ccr_rd_data           (ccr_rd_data),
        .ccr_cur_e             (ccr_cur_e),
        .ecl_alu_cin_e         (ecl_alu_cin_e)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] tid, input logic [7:0] exp);
        rd_tid = tid;
        #1;
        chk(tag, ccr_rd_data, exp);
    endtask

    task automatic chk_cur(input string tag, input logic [1:0] tid, input logic [7:0] exp);
        tid_e = tid;
        #1;
        chk(tag, ccr_cur_e, exp);
        chk({tag, "_cin"}, {7'd0, ecl_alu_cin_e}, {7'd0, exp[0]});
    endtask

    task automatic idle(input logic [1:0] tid);
        valid_e = 1'b0; setcc_e = 1'b0; wrccr_e = 1'b0; tid_e = tid;
    endtask

    // Adder op on 64-bit operands; the ALU's flag bits are derived from real arithmetic.
    task automatic drive_arith(input logic [1:0] tid, input logic [63:0] a, input logic [63:0] b,
                               input logic sub);
        logic [63:0] b2;
        logic [64:0] s;
        logic [32:0] s32;
        b2  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, b2} + 65'(sub);
        s32 = {1'b0, a[31:0]} + {1'b0, b2[31:0]} + 33'(sub);
        valid_e = 1'b1; tid_e = tid; setcc_e = 1'b1; wrccr_e = 1'b0;
        is_logic_e = 1'b0; is_sub_e = sub;
        rs1_63_e = a[63]; rs1_31_e = a[31]; in2_63 = b2[63]; in2_31 = b2[31];
        add_n64 = s[63]; add_n32 = s[31];
        log_n64 = ~s[63]; log_n32 = ~s[31];
        zhigh = (s[63:32] == 32'd0); zlow = (s[31:0] == 32'd0);
        cout64_l = ~s[64]; cout32 = s32[32];
    endtask

    // Logic op; adder-side bits are set to conflicting junk so the select matters.
    task automatic drive_logic(input logic [1:0] tid, input logic [63:0] r);
        valid_e = 1'b1; tid_e = tid; setcc_e = 1'b1; wrccr_e = 1'b0;
        is_logic_e = 1'b1; is_sub_e = 1'b0;
        log_n64 = r[63]; log_n32 = r[31];
        add_n64 = ~r[63]; add_n32 = ~r[31];
        rs1_63_e = 1'b0; rs1_31_e = 1'b0; in2_63 = 1'b0; in2_31 = 1'b0;
        zhigh = (r[63:32] == 32'd0); zlow = (r[31:0] == 32'd0);
        cout64_l = 1'b0; cout32 = 1'b1;
    endtask

    initial begin
        arst_l = 1'b0; se = 1'b0; si = 1'b0;
        flush_m = 1'b0; flush_w = 1'b0; rd_tid = 2'd0;
        is_logic_e = 1'b0; is_sub_e = 1'b0; wrccr_data_e = 8'h00;
        drive_logic(2'd0, 64'd0);
        idle(2'd0);
        tick(); tick();
        chk("rst_rd0", ccr_rd_data, 8'h00);
        chk("rst_so", {7'd0, so}, 8'h00);
        chk_cur("rst_cur", 2'd0, 8'h00);
        #1 arst_l = 1'b1;
        tick();

        // tid1: 0x7FFF_FFFF + 1 -> icc N,V
        drive_arith(2'd1, 64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0);
        tick();
        idle(2'd1);
        chk_cur("add_fwd_m", 2'd1, 8'h0A);
        chk_cur("add_other_tid", 2'd2, 8'h00);
        chk_rd("add_rd_e1", 2'd1, 8'h00);
        tick();
        chk_cur("add_fwd_w", 2'd1, 8'h0A);
        chk_rd("add_rd_e2", 2'd1, 8'h00);
        tick();
        chk_rd("add_rd_e3", 2'd1, 8'h0A);

        // tid2: 5-5 then 3-5 back to back
        drive_arith(2'd2, 64'd5, 64'd5, 1'b1);
        tick();
        drive_arith(2'd2, 64'd3, 64'd5, 1'b1);
        tick();
        idle(2'd0);
        tick();
        chk_rd("sub_zero", 2'd2, 8'h44);
        tick();
        chk_rd("sub_borrow", 2'd2, 8'h99);

        // tid0: op1 sets icc.C, op2 logic; M beats W
        drive_arith(2'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        tick();
        drive_logic(2'd0, 64'h8000_0000_0000_0000);
        chk_cur("b2b_op1_fwd", 2'd0, 8'h05);
        tick();
        idle(2'd0);
        chk_cur("b2b_youngest", 2'd0, 8'h84);
        tick();
        chk_cur("b2b_w_fwd", 2'd0, 8'h84);
        chk_rd("b2b_op1_commit", 2'd0, 8'h05);
        tick();
        chk_rd("b2b_op2_commit", 2'd0, 8'h84);

        // tid3: flush in M
        drive_logic(2'd3, 64'd0);
        tick();
        idle(2'd3);
        flush_m = 1'b1;
        chk_cur("flm_no_fwd_m", 2'd3, 8'h00);
        tick();
        flush_m = 1'b0;
        chk_cur("flm_no_fwd_w", 2'd3, 8'h00);
        tick(); tick();
        chk_rd("flm_no_commit", 2'd3, 8'h00);

        // tid3: flush in W
        drive_logic(2'd3, 64'd0);
        tick();
        idle(2'd3);
        tick();
        flush_w = 1'b1;
        chk_cur("flw_no_fwd", 2'd3, 8'h00);
        tick();
        flush_w = 1'b0;
        chk_rd("flw_no_commit", 2'd3, 8'h00);

        // tid3: both flushes in the same cycle
        drive_logic(2'd3, 64'd0);
        tick();
        drive_arith(2'd3, 64'd3, 64'd5, 1'b1);
        tick();
        idle(2'd3);
        flush_m = 1'b1; flush_w = 1'b1;
        chk_cur("flmw_no_fwd", 2'd3, 8'h00);
        tick();
        flush_m = 1'b0; flush_w = 1'b0;
        tick();
        chk_rd("flmw_no_commit", 2'd3, 8'h00);

        // setcc with valid_e low never commits
        drive_logic(2'd1, 64'd0);
        valid_e = 1'b0;
        tick();
        idle(2'd1);
        chk_cur("inv_no_fwd", 2'd1, 8'h0A);
        tick(); tick();
        chk_rd("inv_no_commit", 2'd1, 8'h0A);

        // tid3: WRCCR 0xFF beats simultaneous setcc flags
        drive_logic(2'd3, 64'd0);
        wrccr_e = 1'b1; wrccr_data_e = 8'hFF;
        tick();
        idle(2'd0);
        tick(); tick();
        chk_rd("wr_t3", 2'd3, 8'hFF);
        chk_rd("wr_t0", 2'd0, 8'h84);
        chk_rd("wr_t1", 2'd1, 8'h0A);
        chk_rd("wr_t2", 2'd2, 8'h99);

        // reset with ops in M and W: everything cleared, nothing commits afterwards
        drive_arith(2'd2, 64'd5, 64'd5, 1'b1);
        tick();
        drive_logic(2'd2, 64'd1);
        tick();
        idle(2'd2);
        arst_l = 1'b0;
        chk_rd("amid_t2", 2'd2, 8'h00);
        chk_rd("amid_t3", 2'd3, 8'h00);
        chk_cur("amid_cur", 2'd2, 8'h00);
        tick();
        arst_l = 1'b1;
        tick(); tick(); tick();
        chk_rd("apost_t2", 2'd2, 8'h00);
        chk_rd("apost_t0", 2'd0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
